// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative compare unit.
// Holds funct3 codes, FSM encodings and result decode helpers.
package cmp_pkg;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic taken;
    logic less;
    logic eq;
  } cmp_result_t;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_SLT) || (op == OP_BLT) || (op == OP_BGE);
  endfunction

  // Maps the raw less/eq flags onto the branch-taken or set-less-than bit.
  function automatic logic decode_taken(input logic [2:0] op, input logic less, input logic eq);
    logic r;
    case (op)
      OP_BEQ:                             r = eq;
      OP_BNE:                             r = ~eq;
      OP_SLT, OP_SLTU, OP_BLT, OP_BLTU:   r = less;
      default:                            r = ~less;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one operand chunk.
module cmp_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/iter_cmp_unit.sv
// Multi-cycle operand comparator scanning CHUNK bits per cycle from the MSB,
// decoding RISC-V funct3 into a taken/set result behind valid/ready handshakes.
module iter_cmp_unit
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHUNK      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_less,
  output logic             out_eq,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state, state_d;
  logic [IDXW-1:0]   idx, idx_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              decided, decided_d;
  logic              dec_less, dec_less_d;
  cmp_result_t       res_q, res_d;
  logic              out_valid_d, in_ready_d, busy_d;

  logic [CHUNK-1:0]  ca, cb;
  logic              c_lt, c_eq;
  logic              last;

  // Select the chunk currently under comparison, MSB chunk first.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        ca = a_q[WIDTH-1-i*CHUNK -: CHUNK];
        cb = b_q[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
  end

  assign last = (idx == IDXW'(NCHUNK-1));

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (ca),
    .b  (cb),
    .lt (c_lt),
    .eq (c_eq)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    decided_d   = decided;
    dec_less_d  = dec_less;
    res_d       = res_q;
    out_valid_d = out_valid;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          // Flipping the sign bit turns a signed compare into an unsigned one.
          a_d            = a;
          b_d            = b;
          a_d[WIDTH-1]   = a[WIDTH-1] ^ is_signed(op);
          b_d[WIDTH-1]   = b[WIDTH-1] ^ is_signed(op);
          op_d           = op;
          idx_d          = '0;
          decided_d      = 1'b0;
          dec_less_d     = 1'b0;
          state_d        = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if ((EARLY_EXIT != 0) && !c_eq) begin
          res_d.less  = c_lt;
          res_d.eq    = 1'b0;
          res_d.taken = decode_taken(op_q, c_lt, 1'b0);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          if (!c_eq && !decided) begin
            decided_d  = 1'b1;
            dec_less_d = c_lt;
          end
          if (last) begin
            res_d.less  = decided_d & dec_less_d;
            res_d.eq    = ~decided_d;
            res_d.taken = decode_taken(op_q, decided_d & dec_less_d, ~decided_d);
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            idx_d = idx + IDXW'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      decided   <= 1'b0;
      dec_less  <= 1'b0;
      res_q     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      decided   <= decided_d;
      dec_less  <= dec_less_d;
      res_q     <= res_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

  assign out_taken = res_q.taken;
  assign out_less  = res_q.less;
  assign out_eq    = res_q.eq;

endmodule

// File: tb/tb_iter_cmp_unit.sv
// Scoreboard bench for iter_cmp_unit: three instances (early exit, full scan,
// single-chunk) driven with directed vectors, checked by a negedge monitor.
module tb_iter_cmp_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic [2:0]  in_valid = '0;
  logic [2:0]  out_ready = 3'b111;
  logic [2:0]  in_ready, out_valid, out_taken, out_less, out_eq, busy;

  typedef struct {
    int   k;
    logic taken;
    logic less;
    logic eq;
    int   at;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  logic [2:0] seen = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_cmp_unit u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .op(op), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_taken(out_taken[0]), .out_less(out_less[0]), .out_eq(out_eq[0]), .busy(busy[0]));

  iter_cmp_unit #(.EARLY_EXIT(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .op(op), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_taken(out_taken[1]), .out_less(out_less[1]), .out_eq(out_eq[1]), .busy(busy[1]));

  iter_cmp_unit #(.CHUNK(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .op(op), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_taken(out_taken[2]), .out_less(out_less[2]), .out_eq(out_eq[2]), .busy(busy[2]));

  task automatic chk(input string name, input logic act, input logic want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic chkn(input string name, input int act, input int want);
    nvec++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Monitor: compare on the first cycle of each out_valid assertion.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (out_valid[k]) begin
        if (!seen[k]) begin
          if (q.size() == 0) begin
            chkn($sformatf("unexpected_result_dut%0d", k), 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chkn("result_instance", k, e.k);
            chk($sformatf("taken_dut%0d", k), out_taken[k], e.taken);
            chk($sformatf("less_dut%0d", k), out_less[k], e.less);
            chk($sformatf("eq_dut%0d", k), out_eq[k], e.eq);
            chkn($sformatf("latency_cycle_dut%0d", k), cyc, e.at);
          end
        end
        seen[k] = 1'b1;
      end else begin
        seen[k] = 1'b0;
      end
    end
  end

  task automatic issue(input int k, input logic [31:0] va, input logic [31:0] vb,
                       input logic [2:0] vop, input logic push, input logic taken,
                       input logic less, input logic eq, input int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[k]) chkn("in_ready_timeout", 0, 1);
    a  = va;
    b  = vb;
    op = vop;
    in_valid[k] = 1'b1;
    if (push) q.push_back('{k, taken, less, eq, cyc + 1 + lat});
    @(negedge clk);
    in_valid[k] = 1'b0;
    a = $urandom();
    b = $urandom();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || busy != 3'b000) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chkn("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid[0], 1'b0);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_taken", out_taken[0], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready0", in_ready[0], 1'b1);
    chk("idle_in_ready1", in_ready[1], 1'b1);

    // Early exit instance.
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(0, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 4);
    issue(0, 32'h1234_5678, 32'h1234_5678, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    issue(0, 32'h1234_5600, 32'h1234_5601, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    issue(0, 32'h0010_0000, 32'h0020_0000, 3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 2);
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    drain();

    // Full-scan instance: fixed latency, first difference wins.
    issue(1, 32'h8000_0000, 32'h0000_0000, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    issue(1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    issue(1, 32'h1234_5678, 32'h1234_5678, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1, 4);
    issue(1, 32'h0100_FFFF, 32'h0001_0000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    drain();

    // Single-chunk instance.
    issue(2, 32'h1234_5600, 32'h1234_5601, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    issue(2, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    drain();

    // Back-pressure: result held while out_ready is low.
    out_ready[0] = 1'b0;
    issue(0, 32'h0000_0005, 32'h0000_0007, 3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    for (int t = 0; t < 20 && !out_valid[0]; t++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid[0], 1'b1);
      chk("hold_taken", out_taken[0], 1'b1);
      chk("hold_less", out_less[0], 1'b1);
      chk("hold_in_ready", in_ready[0], 1'b0);
      chk("hold_busy", busy[0], 1'b1);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("release_valid", out_valid[0], 1'b0);
    chk("release_in_ready", in_ready[0], 1'b1);

    // Flush mid-scan, then a request presented together with flush.
    issue(0, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", out_valid[0], 1'b0);
    chk("flush_in_ready", in_ready[0], 1'b1);
    flush = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid[0] = 1'b0;
    chk("flush_blocks_accept", busy[0], 1'b0);
    issue(0, 32'h0000_0005, 32'h0000_0003, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    drain();

    // Asynchronous reset mid-scan.
    issue(0, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid[0], 1'b0);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_taken", out_taken[0], 1'b0);
    chk("rst_eq", out_eq[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 32'h0000_0010, 32'h0000_0020, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    issue(0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    drain();
    chkn("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
